// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with byte-strobed writeback and a
// per-register busy scoreboard used by decode for RAW hazard detection.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rs_addr,
    output logic [NRD*XLEN-1:0]   rs_dout,
    output logic [NRD-1:0]        rs_busy,
    input  logic                  we,
    input  logic [XLEN/8-1:0]     wstrb,
    input  logic [AW-1:0]         rd_addr,
    input  logic [XLEN-1:0]       rd_din,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  any_busy
);

    localparam int  NBYTE = XLEN / 8;
    localparam bit  ZR    = (ZERO_REG != 0);

    logic [XLEN-1:0]   mem_q [NREG];
    logic [XLEN-1:0]   mem_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [NRD*AW-1:0] rs_addr_q;

    logic wr_ok_s;
    logic iss_ok_s;

    // Qualify writeback and issue; a hardwired x0 never accepts either.
    always_comb begin
        wr_ok_s  = we & ~(ZR & (rd_addr == {AW{1'b0}}));
        iss_ok_s = iss_valid & ~(ZR & (iss_rd == {AW{1'b0}}));
    end

    // Next-state for the array and scoreboard; an issue overrides a writeback
    // clear on the same register because a newer producer now owns it.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int r = 0; r < NREG; r++) begin
            if (iss_ok_s && (iss_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_ok_s && (rd_addr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
        for (int b = 0; b < NBYTE; b++) begin
            if (wr_ok_s && wstrb[b]) begin
                mem_d[rd_addr][b*8 +: 8] = rd_din[b*8 +: 8];
            end else begin
                mem_d[rd_addr][b*8 +: 8] = mem_q[rd_addr][b*8 +: 8];
            end
        end
    end

    // Array, scoreboard and read-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= {XLEN{1'b0}};
            end
            busy_q    <= {NREG{1'b0}};
            rs_addr_q <= {(NRD*AW){1'b0}};
        end else begin
            mem_q     <= mem_d;
            busy_q    <= busy_d;
            rs_addr_q <= rs_addr;
        end
    end

    // Asynchronous array read from the registered addresses gives one cycle of
    // latency and makes same-edge writes visible without a bypass.
    always_comb begin
        rs_dout = {(NRD*XLEN){1'b0}};
        rs_busy = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            rs_dout[i*XLEN +: XLEN] = mem_q[rs_addr_q[i*AW +: AW]];
            rs_busy[i]              = busy_q[rs_addr_q[i*AW +: AW]];
        end
    end

    // Drain check for the pipeline.
    always_comb begin
        any_busy = |busy_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: stimulus updates an array-level model of two register files
// (x0 hardwired and x0 ordinary) and queues expected reads; a monitor checks them.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NRD*AW-1:0] rs_addr = '0;
    logic [NRD*XLEN-1:0] dout_a, dout_b;
    logic [NRD-1:0]    busy_a, busy_b;
    logic              any_a, any_b;
    logic              we = 1'b0;
    logic [3:0]        wstrb = 4'h0;
    logic [AW-1:0]     rd_addr = '0;
    logic [XLEN-1:0]   rd_din = '0;
    logic              iss_valid = 1'b0;
    logic [AW-1:0]     iss_rd = '0;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1)) u_a (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_dout(dout_a), .rs_busy(busy_a),
        .we(we), .wstrb(wstrb), .rd_addr(rd_addr), .rd_din(rd_din),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .any_busy(any_a));

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(0)) u_b (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_dout(dout_b), .rs_busy(busy_b),
        .we(we), .wstrb(wstrb), .rd_addr(rd_addr), .rd_din(rd_din),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .any_busy(any_b));

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       tag;
        logic [63:0] da, db;
        logic [1:0]  ba, bb;
        logic        aa, ab;
    } exp_t;

    exp_t        q[$];
    int          ncyc = 0;
    int          nchk = 0;
    int          nfail = 0;
    logic [31:0] mm [2][NREG];
    bit          bz [2][NREG];

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: pop every expectation whose clock edge has happened.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= ncyc) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, " dout zr1"}, {32'h0, dout_a}, e.da);
            chk({e.tag, " dout zr0"}, {32'h0, dout_b}, e.db);
            chk({e.tag, " busy zr1"}, {62'h0, busy_a}, {62'h0, e.ba});
            chk({e.tag, " busy zr0"}, {62'h0, busy_b}, {62'h0, e.bb});
            chk({e.tag, " any zr1"},  {63'h0, any_a},  {63'h0, e.aa});
            chk({e.tag, " any zr0"},  {63'h0, any_b},  {63'h0, e.ab});
        end
    end

    function automatic exp_t snap(input string tag, input int due, input logic [4:0] a0,
                                  input logic [4:0] a1);
        exp_t e;
        e.tag = tag;
        e.due = due;
        e.da  = {32'h0, mm[0][a1], mm[0][a0]};
        e.db  = {32'h0, mm[1][a1], mm[1][a0]};
        e.ba  = {bz[0][a1], bz[0][a0]};
        e.bb  = {bz[1][a1], bz[1][a0]};
        e.aa  = 1'b0;
        e.ab  = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            e.aa = e.aa | bz[0][r];
            e.ab = e.ab | bz[1][r];
        end
        return e;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < NREG; r++) begin
                mm[d][r] = 32'h0;
                bz[d][r] = 1'b0;
            end
    endtask

    // One clock of stimulus, called #1 after a rising edge.
    task automatic cyc(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                       input bit w, input logic [3:0] st, input logic [4:0] rd,
                       input logic [31:0] din, input bit iv, input logic [4:0] ir);
        logic [31:0] mask;
        rs_addr = {a1, a0}; we = w; wstrb = st; rd_addr = rd; rd_din = din;
        iss_valid = iv; iss_rd = ir;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (st[b]) mask = mask | (32'hFF << (8 * b));
        for (int d = 0; d < 2; d++) begin
            bit hard0, wok, iok;
            hard0 = (d == 0);
            wok = w && !(hard0 && rd == 5'd0);
            iok = iv && !(hard0 && ir == 5'd0);
            if (wok) mm[d][rd] = (mm[d][rd] & ~mask) | (din & mask);
            for (int r = 0; r < NREG; r++) begin
                if (iok && ir == r[4:0]) bz[d][r] = 1'b1;
                else if (wok && rd == r[4:0]) bz[d][r] = 1'b0;
            end
        end
        q.push_back(snap(tag, ncyc + 1, a0, a1));
        @(posedge clk);
        #1;
    endtask

    task automatic rd2(input string tag, input logic [4:0] a0, input logic [4:0] a1);
        cyc(tag, a0, a1, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rs_addr = '0; we = 1'b0; wstrb = 4'h0; rd_addr = '0; rd_din = '0;
        iss_valid = 1'b0; iss_rd = '0;
        q.delete();
        model_clear();
        q.push_back(snap("reset now", ncyc, 5'd0, 5'd0));
        @(posedge clk);
        #1;
        q.push_back(snap("reset held", ncyc, 5'd0, 5'd0));
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();

        // Byte strobes
        cyc("x3 fill", 5'd0, 5'd0, 1'b1, 4'hF, 5'd3, 32'hFFFFFFFF, 1'b0, 5'd0);
        cyc("x3 strb", 5'd0, 5'd0, 1'b1, 4'b0101, 5'd3, 32'h11223344, 1'b0, 5'd0);
        rd2("x3 read", 5'd3, 5'd1);

        // Read-after-write on the same edge, then all ports on one register
        cyc("x7 raw", 5'd7, 5'd3, 1'b1, 4'hF, 5'd7, 32'h0000CAFE, 1'b0, 5'd0);
        rd2("x7 both", 5'd7, 5'd7);

        // Register 0 write and issue
        cyc("x0 wr", 5'd0, 5'd0, 1'b1, 4'hF, 5'd0, 32'h12345678, 1'b1, 5'd0);
        rd2("x0 read", 5'd0, 5'd0);
        cyc("x0 clr", 5'd0, 5'd0, 1'b1, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Issue and writeback collide on x9
        cyc("x9 iss", 5'd9, 5'd0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd9);
        cyc("x9 both", 5'd9, 5'd0, 1'b1, 4'hF, 5'd9, 32'h00000099, 1'b1, 5'd9);
        cyc("x9 wb", 5'd9, 5'd0, 1'b1, 4'hF, 5'd9, 32'h00000999, 1'b0, 5'd0);

        // Concurrent set and clear on different registers
        cyc("x4 iss", 5'd4, 5'd12, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd4);
        cyc("x4x12", 5'd4, 5'd12, 1'b1, 4'hF, 5'd4, 32'h44444444, 1'b1, 5'd12);
        rd2("x4x12 rd", 5'd4, 5'd12);
        cyc("x12 wb", 5'd12, 5'd4, 1'b1, 4'hF, 5'd12, 32'h0C0C0C0C, 1'b0, 5'd0);

        // Reset mid-run discards state
        cyc("x5 wr", 5'd5, 5'd0, 1'b1, 4'hF, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5);
        cyc("x5 busy", 5'd5, 5'd0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd6);
        do_reset();
        rd2("x5 post", 5'd5, 5'd6);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 4'($urandom), 5'($urandom_range(0, 31)),
                $urandom, 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
        end
        for (int r = 0; r < NREG; r++) begin
            cyc("drain", 5'(r), 5'(NREG - 1 - r), 1'b1, 4'h0, 5'(r), 32'h0, 1'b0, 5'd0);
        end
        rd2("final", 5'd1, 5'd2);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            nchk++;
            nfail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
